// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands 4 bits per cycle through one carry-lookahead slice.
// Define NSA_OVF_EN to add the registered two's-complement overflow output ovf.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef NSA_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       xa, xb, ns;
  logic             nc;

  // 4-bit carry-lookahead slice; returns {carry-out, sum}
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g, p, c;
    logic       co;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {co, p ^ c};
  endfunction

  always_comb begin
    xa       = a_r[cnt*4 +: 4];
    xb       = b_r[cnt*4 +: 4];
    {nc, ns} = cla4(xa, xb, carry);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
`ifdef NSA_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately not looked at here
          sum[cnt*4 +: 4] <= ns;
          carry           <= nc;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= nc;
`ifdef NSA_OVF_EN
            // carry into the MSB recovered from the slice's top sum bit
            ovf   <= (ns[3] ^ xa[3] ^ xb[3]) ^ nc;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst, start, cin;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;
`ifdef NSA_OVF_EN
  logic             ovf;
`endif

  int tests = 0;
  int fails = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
`ifdef NSA_OVF_EN
    .ovf  (ovf),
`endif
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // apply start for one accepting edge, then wait (bounded) for done
  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vc, output int lat);
    a = va; b = vb; cin = vc; start = 1'b1;
    step();
    start = 1'b0;
    a = $urandom; b = $urandom; cin = 1'b1;
    lat = 0;
    while (!done && lat < 12) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat, dcount;
    logic [WIDTH-1:0] ga [3];
    logic [WIDTH-1:0] gb [3];
    logic             gc [3];
    logic [WIDTH-1:0] gs [3];
    logic             gco [3];

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum",  32'(sum),  32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    step();

    run_op(16'h1234, 16'h4321, 1'b0, lat);
    chk("basic_lat",  32'(lat),  32'd4);
    chk("basic_sum",  32'(sum),  32'h5555);
    chk("basic_cout", 32'(cout), 32'd0);
    chk("basic_busy", 32'(busy), 32'd0);
    step();
    chk("done_pulse", 32'(done), 32'd0);
    chk("sum_hold",   32'(sum),  32'h5555);

    run_op(16'hFFFF, 16'h0001, 1'b0, lat);
    chk("wrap_lat",  32'(lat),  32'd4);
    chk("wrap_sum",  32'(sum),  32'h0000);
    chk("wrap_cout", 32'(cout), 32'd1);
`ifdef NSA_OVF_EN
    chk("wrap_ovf",  32'(ovf),  32'd0);
`endif
    step();

    run_op(16'h7FFF, 16'h0000, 1'b1, lat);
    chk("ovf_lat",  32'(lat),  32'd4);
    chk("ovf_sum",  32'(sum),  32'h8000);
    chk("ovf_cout", 32'(cout), 32'd0);
`ifdef NSA_OVF_EN
    chk("ovf_ovf",  32'(ovf),  32'd1);
`endif
    step();

    // start during RUN must be ignored
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      start = (i == 2);
      a = 16'h0001; b = 16'h0001;
      step();
      if (i < 4) chk("ign_busy", 32'(busy), 32'd1);
    end
    start = 1'b0;
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_sum",  32'(sum),  32'h0100);
    chk("ign_cout", 32'(cout), 32'd0);
    step();
    chk("ign_idle", 32'(busy), 32'd0);

    // reset mid-RUN aborts with no done pulse
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) dcount++;
    end
    chk("rst_nodone", 32'(dcount), 32'd0);

    // start held high: accepts at edges 0, 5, 10
    ga[0] = 16'h1111; gb[0] = 16'h2222; gc[0] = 1'b0; gs[0] = 16'h3333; gco[0] = 1'b0;
    ga[1] = 16'h8000; gb[1] = 16'h8000; gc[1] = 1'b1; gs[1] = 16'h0001; gco[1] = 1'b1;
    ga[2] = 16'h0F0F; gb[2] = 16'h00F1; gc[2] = 1'b0; gs[2] = 16'h1000; gco[2] = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i % 5 == 0) begin
        a = ga[i/5]; b = gb[i/5]; cin = gc[i/5];
      end else begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      end
      step();
      chk("b2b_done", 32'(done), (i % 5 == 4) ? 32'd1 : 32'd0);
      if (i % 5 == 4) begin
        chk("b2b_sum",  32'(sum),  32'(gs[i/5]));
        chk("b2b_cout", 32'(cout), 32'(gco[i/5]));
      end
    end
    start = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4, minimum 8.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on clk.
REQ-005 SHALL have port a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while nibbles are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL have port sum  output  WIDTH  registered result.
REQ-011 SHALL have port cout  output  1  registered carry-out of the MSB nibble.

Function
REQ-012 SHALL add a, b and cin serially, 4 bits per cycle, through one internal 4-bit carry-lookahead add slice: nibble k uses a[4k+3:4k], b[4k+3:4k] and the carry registered from nibble k-1 (cin for k=0).
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; the reset state is IDLE.
REQ-014 IDLE: start=1 -> capture a, b, cin; clear nibble counter; go to RUN. start=0 -> stay in IDLE.
REQ-015 RUN: each cycle processes one nibble, writes sum[4k+3:4k] and updates the carry register; after nibble WIDTH/4-1 -> go to DONE, with cout set to the final carry.
REQ-016 DONE: done=1 for exactly this one cycle; start=1 -> act as in IDLE (back-to-back accept); otherwise -> go to IDLE.
REQ-017 Latency: when start is sampled at edge E0, done SHALL be high in the cycle after edge E(WIDTH/4); for WIDTH=16, done is high 4 cycles after E0.
REQ-018 busy SHALL equal (state==RUN); busy and done SHALL never be high together.
REQ-019 start while busy=1 SHALL be ignored; captured operands and progress SHALL be unaffected.
REQ-020 Changes to a, b and cin after acceptance SHALL not affect the result.
REQ-021 sum and cout SHALL hold their last result from DONE until the next accepted start; partial sums are visible during RUN but are valid only when done=1.
REQ-022 The result is unsigned modulo 2^WIDTH; cout SHALL be the bit-WIDTH carry.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE and set busy=0, done=0, sum=0, cout=0, the counter to 0 and the carry register to 0.
REQ-024 rst SHALL take priority over start and over any in-flight operation; reset asserted mid-RUN SHALL abort the operation and no done pulse SHALL follow.

Configuration
REQ-025 Macro NSA_OVF_EN: when it is defined, SHALL add port ovf  output  1, the registered two's-complement overflow, computed as (carry into MSB) XOR cout and updated with cout.
REQ-026 ovf SHALL reset to 0 and hold its value with sum; when NSA_OVF_EN is undefined, the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-027 WIDTH=16; a=0x1234, b=0x4321, cin=0, start pulse -> done 4 cycles later, sum=0x5555, cout=0.
REQ-028 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (with NSA_OVF_EN defined); a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
REQ-029 Assert start again with a=0x0001, b=0x0001 at cycle 2 of a 0x00FF+0x0001 operation -> it is ignored; result sum=0x0100, and busy stays high until done.
REQ-030 Assert rst in cycle 2 of RUN -> next cycle busy=0, sum=0, cout=0; no done pulse within the following 8 cycles.
REQ-031 Hold start=1 continuously with changing operands -> one done pulse every 5 cycles; each sum matches the operands captured at its acceptance edge.
